// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: two requester ports plus the shared data-memory port.
// slave is the arbiter side; master is the requester/memory side.
interface data_memory_arbiter_if;
    logic        req0, req1, we0, we1, ack0, ack1, err;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] addr0, addr1, wdata0, wdata1, rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  be0, be1, mem_be;
    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1, mem_ready, mem_rdata,
        output ack0, ack1, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
    modport master (
        output req0, req1, we0, we1, addr0, addr1, be0, be1, wdata0, wdata1, mem_ready, mem_rdata,
        input  ack0, ack1, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares one data-memory port between pipeline (0) and loader (1), one access in flight.
// Define DMEM_ARB_ROUND_ROBIN_EN to break ties round-robin instead of fixed port-0 priority.
module data_memory_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input logic                  clk,
    input logic                  reset_n,
    data_memory_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
    state_t           state, next;
    logic [TMO_W-1:0] cnt;
    logic             start, win, win_q, tmo, done;
    logic             mem_req_d, ack0_d, ack1_d, err_d;
    logic             mem_req_q, mem_we_q, ack0_q, ack1_q, err_q;
    logic [31:0]      mem_addr_q, mem_wdata_q, rdata_q;
    logic [3:0]       mem_be_q;
    assign start = bus.req0 | bus.req1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_grant;
    assign win = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) last_grant <= 1'b1;
        else if (state == IDLE && start) last_grant <= win;
`else
    assign win = ~bus.req0;
`endif
    // a mem_ready in the timeout cycle still completes the access normally
    assign tmo  = (TIMEOUT_CYCLES != 0) && (cnt == TMO_LAST);
    assign done = bus.mem_ready | tmo;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state == IDLE  ? (start ? ISSUE : IDLE) :
               state == ISSUE ? (done ? RESP : ISSUE) : IDLE;
    end
    always_comb begin
        mem_req_d = next == ISSUE;
        ack0_d    = state == ISSUE && done && !win_q;
        ack1_d    = state == ISSUE && done && win_q;
        err_d     = state == ISSUE && done && !bus.mem_ready;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            win_q       <= 1'b0;
            cnt         <= '0;
        end else begin
            mem_req_q <= mem_req_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err_q     <= err_d;
            if (state == IDLE && start) begin
                mem_we_q    <= win ? bus.we1 : bus.we0;
                mem_addr_q  <= win ? bus.addr1 : bus.addr0;
                mem_be_q    <= win ? bus.be1 : bus.be0;
                mem_wdata_q <= win ? bus.wdata1 : bus.wdata0;
                win_q       <= win;
                cnt         <= '0;
            end else if (state == ISSUE) cnt <= cnt + TMO_W'(1);
            if (state == ISSUE && bus.mem_ready && !mem_we_q) rdata_q <= bus.mem_rdata;
        end
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed checks of arbitration, latency, timeout and reset (TIMEOUT_CYCLES=4).
module tb_data_memory_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    data_memory_arbiter_if bus();
    data_memory_arbiter #(.TIMEOUT_CYCLES(4), .TMO_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata);
        if (port == 0) begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.be0 = be; bus.wdata0 = wdata;
        end else begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.be1 = be; bus.wdata1 = wdata;
        end
    endtask

    task automatic test_reset();
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0; bus.addr0 = 0; bus.addr1 = 0;
        bus.be0 = 0; bus.be1 = 0; bus.wdata0 = 0; bus.wdata1 = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
        reset_n = 1'b0;
        repeat (2) step();
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.ack0, bus.ack1, bus.err} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {bus.mem_req, bus.mem_we, bus.ack0, bus.ack1, bus.err}); end
        n_checks++; if ({bus.mem_addr, bus.mem_wdata, bus.rdata, bus.mem_be} !== 100'b0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {bus.mem_addr, bus.mem_wdata, bus.rdata, bus.mem_be}); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_load();
        drive(0, 1'b0, 32'h100, 4'hF, 32'h0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        step();
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.ack0} !== 3'b100) begin n_fail++; $display("FAIL load_issue: got %b expected 100", {bus.mem_req, bus.mem_we, bus.ack0}); end
        n_checks++; if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL load_addr: got %h expected 00000100", bus.mem_addr); end
        step();
        n_checks++; if ({bus.ack0, bus.ack1, bus.err, bus.mem_req} !== 4'b1000) begin n_fail++; $display("FAIL load_ack: got %b expected 1000", {bus.ack0, bus.ack1, bus.err, bus.mem_req}); end
        n_checks++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata: got %h expected deadbeef", bus.rdata); end
        bus.req0 = 1'b0; bus.mem_ready = 1'b0;
        step();
        n_checks++; if (bus.ack0 !== 1'b0) begin n_fail++; $display("FAIL load_ack_pulse: got %b expected 0", bus.ack0); end
    endtask

    task automatic test_store_wait();
        int high = 0;
        int acks = 0;
        drive(1, 1'b1, 32'h202, 4'b0100, 32'h00AB0000);
        bus.mem_rdata = 32'h12345678;
        step();
        n_checks++; if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'b0100, 32'h202, 32'h00AB0000}) begin n_fail++; $display("FAIL store_fields: got %h", {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}); end
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_req) high++;
            if (i == 3) bus.mem_ready = 1'b1;
            else step();
        end
        step();
        n_checks++; if (high !== 4) begin n_fail++; $display("FAIL store_req_cycles: got %0d expected 4", high); end
        n_checks++; if ({bus.ack1, bus.ack0, bus.err, bus.mem_req} !== 4'b1000) begin n_fail++; $display("FAIL store_ack: got %b expected 1000", {bus.ack1, bus.ack0, bus.err, bus.mem_req}); end
        n_checks++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_rdata_hold: got %h expected deadbeef", bus.rdata); end
        acks += int'(bus.ack1);
        bus.req1 = 1'b0; bus.mem_ready = 1'b0;
        repeat (3) begin step(); acks += int'(bus.ack1); end
        n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL store_ack_count: got %0d expected 1", acks); end
    endtask

    task automatic test_back_to_back();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        logic [31:0] second_addr = 32'h400;
        logic [1:0]  second_ack = 2'b01;
`else
        logic [31:0] second_addr = 32'h300;
        logic [1:0]  second_ack = 2'b10;
`endif
        drive(0, 1'b0, 32'h300, 4'hF, 32'h0);
        drive(1, 1'b0, 32'h400, 4'hF, 32'h0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11111111;
        step();
        n_checks++; if (bus.mem_addr !== 32'h300) begin n_fail++; $display("FAIL b2b_first_addr: got %h expected 00000300", bus.mem_addr); end
        step();
        n_checks++; if ({bus.ack0, bus.ack1} !== 2'b10 || bus.rdata !== 32'h11111111) begin n_fail++; $display("FAIL b2b_first_ack: got %b/%h expected 10/11111111", {bus.ack0, bus.ack1}, bus.rdata); end
        bus.req0 = 1'b0; bus.mem_rdata = 32'h22222222;
        step();
        bus.req0 = 1'b1;
        step();
        n_checks++; if (bus.mem_addr !== second_addr) begin n_fail++; $display("FAIL b2b_second_addr: got %h expected %h", bus.mem_addr, second_addr); end
        step();
        n_checks++; if ({bus.ack0, bus.ack1} !== second_ack || bus.rdata !== 32'h22222222) begin n_fail++; $display("FAIL b2b_second_ack: got %b/%h expected %b/22222222", {bus.ack0, bus.ack1}, bus.rdata, second_ack); end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_timeout();
        int high = 0;
        bit got_ack = 0;
        drive(0, 1'b0, 32'h500, 4'hF, 32'h0);
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'hBADBAD00;
        step();
        for (int i = 0; i < 12 && !got_ack; i++) begin
            if (bus.mem_req) high++;
            if (bus.ack0) got_ack = 1;
            else step();
        end
        n_checks++; if (!got_ack) begin n_fail++; $display("FAIL tmo_ack: no ack0 within 12 cycles"); end
        n_checks++; if (high !== 4) begin n_fail++; $display("FAIL tmo_req_cycles: got %0d expected 4", high); end
        n_checks++; if ({bus.err, bus.rdata} !== {1'b1, 32'h22222222}) begin n_fail++; $display("FAIL tmo_err: got %b/%h expected 1/22222222", bus.err, bus.rdata); end
        bus.req0 = 1'b0;
        step();
        drive(1, 1'b0, 32'h600, 4'hF, 32'h0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0C0FFEE0;
        repeat (2) step();
        n_checks++; if ({bus.ack1, bus.err, bus.rdata} !== {2'b10, 32'h0C0FFEE0}) begin n_fail++; $display("FAIL tmo_next: got %b%b/%h expected 10/0c0ffee0", bus.ack1, bus.err, bus.rdata); end
        bus.req1 = 1'b0; bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        drive(0, 1'b0, 32'h700, 4'hF, 32'h0);
        bus.mem_ready = 1'b0;
        repeat (2) step();
        reset_n = 1'b0;
        #1;
        n_checks++; if ({bus.mem_req, bus.ack0, bus.mem_addr, bus.rdata} !== 66'b0) begin n_fail++; $display("FAIL rst_mid: got %b%b/%h/%h expected all 0", bus.mem_req, bus.ack0, bus.mem_addr, bus.rdata); end
        bus.req0 = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (2) begin step(); acks += int'(bus.ack0 | bus.mem_req); end
        n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL rst_dropped: got %0d activity cycles expected 0", acks); end
        drive(0, 1'b0, 32'h704, 4'hF, 32'h0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5555AAAA;
        step();
        n_checks++; if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h704}) begin n_fail++; $display("FAIL rst_new_issue: got %b/%h expected 1/00000704", bus.mem_req, bus.mem_addr); end
        step();
        n_checks++; if ({bus.ack0, bus.err, bus.rdata} !== {2'b10, 32'h5555AAAA}) begin n_fail++; $display("FAIL rst_new_ack: got %b%b/%h expected 10/5555aaaa", bus.ack0, bus.err, bus.rdata); end
        bus.req0 = 1'b0; bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_ready_at_timeout();
        drive(0, 1'b0, 32'h800, 4'hF, 32'h0);
        bus.mem_ready = 1'b0;
        repeat (4) step();
        n_checks++; if ({bus.mem_req, bus.ack0} !== 2'b10) begin n_fail++; $display("FAIL race_issue: got %b expected 10", {bus.mem_req, bus.ack0}); end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h66778899;
        step();
        n_checks++; if ({bus.ack0, bus.err, bus.rdata} !== {2'b10, 32'h66778899}) begin n_fail++; $display("FAIL race_ack: got %b%b/%h expected 10/66778899", bus.ack0, bus.err, bus.rdata); end
        bus.req0 = 1'b0; bus.mem_ready = 1'b0;
        step();
    endtask

    task automatic test_store_be_zero();
        drive(0, 1'b1, 32'h900, 4'b0000, 32'hCAFEF00D);
        bus.mem_ready = 1'b1;
        step();
        n_checks++; if ({bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata} !== {2'b11, 4'b0000, 32'hCAFEF00D}) begin n_fail++; $display("FAIL be0_issue: got %h", {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_wdata}); end
        step();
        n_checks++; if ({bus.ack0, bus.rdata} !== {1'b1, 32'h66778899}) begin n_fail++; $display("FAIL be0_ack: got %b/%h expected 1/66778899", bus.ack0, bus.rdata); end
        bus.req0 = 1'b0; bus.mem_ready = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store_wait();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_ready_at_timeout();
        test_store_be_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
